// File: rtl/xdma_wr_burst_reshaper.sv
// Splits one XDMA write request into legal AXI4 INCR bursts (<=256 beats, optional 4 KiB split).
// Define XDMA_RESHAPER_4K_SPLIT_EN to keep every burst inside a 4 KiB page.
module xdma_wr_burst_reshaper #(
    parameter int AddrWidth = 48,
    parameter int DataWidth = 512,
    parameter int LenWidth  = 32,
    parameter int IdWidth   = 8,
    parameter int IdxWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 write_req_done_i,
    input  logic [IdWidth-1:0]   write_req_dma_id_i,
    input  logic                 write_req_dma_type_i,
    input  logic [AddrWidth-1:0] write_req_remote_addr_i,
    input  logic [LenWidth-1:0]  write_req_dma_length_i,
    input  logic [IdxWidth-1:0]  write_req_idx_i,
    input  logic                 write_req_desc_valid_i,
    output logic [AddrWidth-1:0] aw_addr_o,
    output logic [7:0]           aw_len_o,
    output logic [2:0]           aw_size_o,
    output logic [1:0]           aw_burst_o,
    output logic [IdWidth-1:0]   aw_id_o,
    output logic [8:0]           w_num_beats_o,
    output logic                 w_last_burst_o,
    output logic [IdxWidth-1:0]  w_idx_o,
    output logic                 w_dma_type_o,
    output logic                 write_req_desc_valid_o,
    input  logic                 write_req_desc_ready_i
);

    localparam int BytesPerBeat = DataWidth / 8;
    localparam int SizeLog      = $clog2(BytesPerBeat);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [AddrWidth-1:0]  addr_q;
    logic [LenWidth-1:0]   remaining_q;
    logic [IdWidth-1:0]    id_q;
    logic [IdxWidth-1:0]   idx_q;
    logic                  type_q;
    logic [8:0]            beats;
    logic                  last_burst;
    logic                  in_issue;

`ifdef XDMA_RESHAPER_4K_SPLIT_EN
    logic [12:0]           beats_to_4k;
`endif

    // Current burst length derives purely from the registered cursor, so it is stable under stall.
    always_comb begin
        beats = (remaining_q >= LenWidth'(256)) ? 9'd256 : remaining_q[8:0];
`ifdef XDMA_RESHAPER_4K_SPLIT_EN
        beats_to_4k = (13'd4096 - {1'b0, addr_q[11:0]}) >> SizeLog;
        if ({4'b0000, beats} > beats_to_4k) begin
            beats = beats_to_4k[8:0];
        end
`endif
    end

    assign last_burst = (LenWidth'(beats) == remaining_q);
    assign in_issue   = (state_q == ISSUE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (write_req_desc_valid_i) begin
                    state_d = (write_req_dma_length_i == '0) ? WAIT_DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (write_req_desc_ready_i && last_burst) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (write_req_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch in IDLE; cursor advance on each accepted burst.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            remaining_q <= '0;
            id_q        <= '0;
            idx_q       <= '0;
            type_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (write_req_desc_valid_i) begin
                        addr_q      <= write_req_remote_addr_i & ~AddrWidth'(BytesPerBeat - 1);
                        remaining_q <= write_req_dma_length_i;
                        id_q        <= write_req_dma_id_i;
                        idx_q       <= write_req_idx_i;
                        type_q      <= write_req_dma_type_i;
                    end
                end
                ISSUE: begin
                    if (write_req_desc_ready_i) begin
                        addr_q      <= addr_q + (AddrWidth'(beats) << SizeLog);
                        remaining_q <= remaining_q - LenWidth'(beats);
                    end
                end
                default: ;
            endcase
        end
    end

    assign aw_addr_o              = addr_q;
    assign aw_len_o               = in_issue ? 8'(beats - 9'd1) : 8'd0;
    assign aw_size_o              = 3'(SizeLog);
    assign aw_burst_o             = 2'b01;
    assign aw_id_o                = id_q;
    assign w_num_beats_o          = in_issue ? beats : 9'd0;
    assign w_last_burst_o         = in_issue & last_burst;
    assign w_idx_o                = idx_q;
    assign w_dma_type_o           = type_q;
    assign write_req_desc_valid_o = in_issue;

endmodule

// File: tb/tb_xdma_wr_burst_reshaper.sv
// Self-checking bench for xdma_wr_burst_reshaper: a burst-list model drives a per-cycle compare.
// Honours XDMA_RESHAPER_4K_SPLIT_EN the same way the design does.
module tb_xdma_wr_burst_reshaper;

    localparam int BPB = 64;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        write_req_done_i = 1'b0;
    logic [7:0]  write_req_dma_id_i = '0;
    logic        write_req_dma_type_i = 1'b0;
    logic [47:0] write_req_remote_addr_i = '0;
    logic [31:0] write_req_dma_length_i = '0;
    logic [7:0]  write_req_idx_i = '0;
    logic        write_req_desc_valid_i = 1'b0;
    logic [47:0] aw_addr_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o;
    logic [1:0]  aw_burst_o;
    logic [7:0]  aw_id_o;
    logic [8:0]  w_num_beats_o;
    logic        w_last_burst_o;
    logic [7:0]  w_idx_o;
    logic        w_dma_type_o;
    logic        write_req_desc_valid_o;
    logic        write_req_desc_ready_i = 1'b0;

    int check_count = 0;
    int pass_count  = 0;
    int ready_mode  = 0;

    typedef struct packed {
        logic [47:0] addr;
        logic [7:0]  len;
        logic [8:0]  beats;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  idx;
        logic        typ;
    } burst_t;

    burst_t exp_q[$];

    xdma_wr_burst_reshaper dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .write_req_done_i        (write_req_done_i),
        .write_req_dma_id_i      (write_req_dma_id_i),
        .write_req_dma_type_i    (write_req_dma_type_i),
        .write_req_remote_addr_i (write_req_remote_addr_i),
        .write_req_dma_length_i  (write_req_dma_length_i),
        .write_req_idx_i         (write_req_idx_i),
        .write_req_desc_valid_i  (write_req_desc_valid_i),
        .aw_addr_o               (aw_addr_o),
        .aw_len_o                (aw_len_o),
        .aw_size_o               (aw_size_o),
        .aw_burst_o              (aw_burst_o),
        .aw_id_o                 (aw_id_o),
        .w_num_beats_o           (w_num_beats_o),
        .w_last_burst_o          (w_last_burst_o),
        .w_idx_o                 (w_idx_o),
        .w_dma_type_o            (w_dma_type_o),
        .write_req_desc_valid_o  (write_req_desc_valid_o),
        .write_req_desc_ready_i  (write_req_desc_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Burst list straight from the rules: cap at 256 beats and, when enabled, at the 4 KiB page end.
    task automatic model_push(input logic [47:0] addr, input int unsigned len,
                              input logic [7:0] id, input logic [7:0] idx, input logic typ);
        longint unsigned a;
        longint unsigned rem;
        longint unsigned b;
        burst_t e;
        a   = longint'(addr) & 64'h0000_FFFF_FFFF_FFC0;
        rem = len;
        while (rem > 0) begin
            b = (rem < 256) ? rem : 256;
`ifdef XDMA_RESHAPER_4K_SPLIT_EN
            begin
                longint unsigned room;
                room = (4096 - (a % 4096)) / BPB;
                if (room < b) b = room;
            end
`endif
            e.addr  = a[47:0];
            e.len   = 8'(b - 1);
            e.beats = 9'(b);
            e.last  = (b == rem);
            e.id    = id;
            e.idx   = idx;
            e.typ   = typ;
            exp_q.push_back(e);
            a   = (a + b * BPB) & 64'h0000_FFFF_FFFF_FFFF;
            rem = rem - b;
        end
    endtask

    task automatic apply_stimulus(input logic [47:0] addr, input int unsigned len,
                                  input logic [7:0] id, input logic [7:0] idx, input logic typ);
        write_req_remote_addr_i = addr;
        write_req_dma_length_i  = len;
        write_req_dma_id_i      = id;
        write_req_idx_i         = idx;
        write_req_dma_type_i    = typ;
        write_req_desc_valid_i  = 1'b1;
        @(posedge clk_i);
        #1 write_req_desc_valid_i = 1'b0;
        if (len != 0) begin
            @(negedge clk_i);
            check_output("valid_rise", {63'b0, write_req_desc_valid_o}, 64'd1);
        end else begin
            repeat (3) begin
                @(negedge clk_i);
                check_output("zero_len_no_valid", {63'b0, write_req_desc_valid_o}, 64'd0);
            end
        end
    endtask

    task automatic finish_request();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk_i);
            #1 n++;
        end
        check_output("drain_done", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk_i);
        #1 check_output("valid_after_last", {63'b0, write_req_desc_valid_o}, 64'd0);
        write_req_done_i = 1'b1;
        @(posedge clk_i);
        #1 write_req_done_i = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                0:       write_req_desc_ready_i = 1'b1;
                1:       write_req_desc_ready_i = 1'($urandom_range(0, 1));
                default: write_req_desc_ready_i = 1'b0;
            endcase
        end
    end

    // Every presented descriptor must equal the head of the model list; a handshake retires it.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && write_req_desc_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_output("spurious_burst", {63'b0, write_req_desc_valid_o}, 64'd0);
                end else begin
                    check_output("aw_addr", 64'(aw_addr_o), 64'(exp_q[0].addr));
                    check_output("aw_len", 64'(aw_len_o), 64'(exp_q[0].len));
                    check_output("w_num_beats", 64'(w_num_beats_o), 64'(exp_q[0].beats));
                    check_output("w_last_burst", 64'(w_last_burst_o), 64'(exp_q[0].last));
                    check_output("aw_id", 64'(aw_id_o), 64'(exp_q[0].id));
                    check_output("w_idx", 64'(w_idx_o), 64'(exp_q[0].idx));
                    check_output("w_dma_type", 64'(w_dma_type_o), 64'(exp_q[0].typ));
                    check_output("aw_burst", 64'(aw_burst_o), 64'd1);
                    check_output("aw_size", 64'(aw_size_o), 64'd6);
                    if (write_req_desc_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [47:0] addr;
        int unsigned len;

        rst_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check_output("rst_valid", 64'(write_req_desc_valid_o), 64'd0);
        check_output("rst_burst", 64'(aw_burst_o), 64'd1);
        check_output("rst_size", 64'(aw_size_o), 64'd6);
        check_output("rst_addr", 64'(aw_addr_o), 64'd0);
        check_output("rst_len", 64'(aw_len_o), 64'd0);
        check_output("rst_beats", 64'(w_num_beats_o), 64'd0);
        check_output("rst_last", 64'(w_last_burst_o), 64'd0);
        check_output("rst_id", 64'(aw_id_o), 64'd0);
        rst_i = 1'b0;
        ready_mode = 0;
        @(posedge clk_i);
        #1;

        $display("[TB] directed: 100 beats at 0x10100000");
        model_push(48'h0000_1010_0000, 100, 8'd99, 8'd3, 1'b1);
`ifdef XDMA_RESHAPER_4K_SPLIT_EN
        check_output("pin_a_count", 64'(exp_q.size()), 64'd2);
        check_output("pin_a_addr1", 64'(exp_q[1].addr), 64'h0000_1010_1000);
        check_output("pin_a_len1", 64'(exp_q[1].len), 64'd35);
        check_output("pin_a_len0", 64'(exp_q[0].len), 64'd63);
`else
        check_output("pin_a_count", 64'(exp_q.size()), 64'd1);
        check_output("pin_a_len0", 64'(exp_q[0].len), 64'd99);
        check_output("pin_a_last0", 64'(exp_q[0].last), 64'd1);
`endif
        check_output("pin_a_addr0", 64'(exp_q[0].addr), 64'h0000_1010_0000);
        apply_stimulus(48'h0000_1010_0000, 100, 8'd99, 8'd3, 1'b1);
        finish_request();

        $display("[TB] directed: 600 beats at 0x0");
        model_push(48'h0, 600, 8'd7, 8'd1, 1'b0);
`ifdef XDMA_RESHAPER_4K_SPLIT_EN
        check_output("pin_b_count", 64'(exp_q.size()), 64'd10);
        check_output("pin_b_len9", 64'(exp_q[9].len), 64'd23);
        check_output("pin_b_last9", 64'(exp_q[9].last), 64'd1);
`else
        check_output("pin_b_count", 64'(exp_q.size()), 64'd3);
        check_output("pin_b_len0", 64'(exp_q[0].len), 64'd255);
        check_output("pin_b_len2", 64'(exp_q[2].len), 64'd87);
        check_output("pin_b_addr2", 64'(exp_q[2].addr), 64'h8000);
        check_output("pin_b_last1", 64'(exp_q[1].last), 64'd0);
        check_output("pin_b_last2", 64'(exp_q[2].last), 64'd1);
`endif
        apply_stimulus(48'h0, 600, 8'd7, 8'd1, 1'b0);
        finish_request();

        $display("[TB] directed: zero length");
        apply_stimulus(48'h0000_0000_2000, 0, 8'd5, 8'd2, 1'b0);
        finish_request();

        $display("[TB] directed: stall with ready low");
        ready_mode = 2;
        model_push(48'h0000_0030_0F00, 100, 8'd11, 8'd4, 1'b1);
        apply_stimulus(48'h0000_0030_0F00, 100, 8'd11, 8'd4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            write_req_done_i = (i == 4);
            @(negedge clk_i);
            check_output("stall_valid", 64'(write_req_desc_valid_o), 64'd1);
        end
        write_req_done_i = 1'b0;
        ready_mode = 0;
        finish_request();

        $display("[TB] directed: reset mid-issue");
        ready_mode = 2;
        model_push(48'h0000_2000_0040, 100, 8'd21, 8'd6, 1'b0);
        apply_stimulus(48'h0000_2000_0040, 100, 8'd21, 8'd6, 1'b0);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_output("rst_mid_valid", 64'(write_req_desc_valid_o), 64'd0);
        rst_i = 1'b0;
        exp_q.delete();
        ready_mode = 0;
        model_push(48'h0000_0500_0080, 40, 8'd22, 8'd7, 1'b1);
        apply_stimulus(48'h0000_0500_0080, 40, 8'd22, 8'd7, 1'b1);
        finish_request();

        $display("[TB] directed: address wrap");
        model_push(48'hFFFF_FFFF_FF00, 300, 8'd33, 8'd8, 1'b0);
        apply_stimulus(48'hFFFF_FFFF_FF00, 300, 8'd33, 8'd8, 1'b0);
        finish_request();

        $display("[TB] random requests");
        for (int r = 0; r < 30; r++) begin
            logic [7:0] id;
            logic [7:0] idx;
            logic       typ;
            ready_mode = int'($urandom_range(0, 1));
            addr = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
            case ($urandom_range(0, 4))
                0:       len = 0;
                1:       len = $urandom_range(1, 8);
                2:       len = $urandom_range(1, 300);
                3:       len = $urandom_range(250, 800);
                default: begin
                    len = $urandom_range(1, 70);
                    addr[11:0] = 12'hFC0 - 12'($urandom_range(0, 3) * 64);
                end
            endcase
            id  = 8'($urandom());
            idx = 8'($urandom());
            typ = 1'($urandom());
            model_push(addr, len, id, idx, typ);
            apply_stimulus(addr, len, id, idx, typ);
            finish_request();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
